// File: rtl/craps_pkg.sv
// Shared types and constants for the craps game controller.
// The craps set is a 16-bit mask indexed by the dice sum.
package craps_pkg;

   typedef enum logic [1:0] {
      COME_OUT = 2'd0,
      POINT    = 2'd1,
      WIN      = 2'd2,
      LOSE     = 2'd3
   } craps_state_t;

   localparam int SUM_W = 4;
   localparam logic [SUM_W-1:0] SUM_MIN = 4'd2;
   localparam logic [SUM_W-1:0] SUM_MAX = 4'd12;
   localparam logic [SUM_W-1:0] SEVEN   = 4'd7;
   localparam logic [SUM_W-1:0] ELEVEN  = 4'd11;

   localparam logic [15:0] CRAPS_MASK = 16'h100C;  // bits 2, 3 and 12

   function automatic logic is_craps(input logic [SUM_W-1:0] s);
      return CRAPS_MASK[s];
   endfunction

endpackage

// File: rtl/craps_classify.sv
// Combinational rule decode for one roll: legality plus win/lose outcome
// for the current phase (come-out or point).
module craps_classify
   import craps_pkg::*;
(
   input  logic [SUM_W-1:0] sum,
   input  logic             in_point,
   input  logic [SUM_W-1:0] point,
   output logic             is_legal,
   output logic             is_win,
   output logic             is_lose
);

   always_comb begin
      is_legal = (sum >= SUM_MIN) && (sum <= SUM_MAX);
      is_win   = 1'b0;
      is_lose  = 1'b0;
      if (is_legal) begin
         if (in_point) begin
            is_win  = (sum == point);
            is_lose = (sum == SEVEN);
         end else begin
            is_win  = (sum == SEVEN) || (sum == ELEVEN);
            is_lose = is_craps(sum);
         end
      end
   end

endmodule

// File: rtl/craps_controller.sv
// Craps game FSM fed by the dice adder: tracks come-out/point/win/lose,
// the stored point and saturating roll/win/loss tallies. All outputs registered.
module craps_controller
   import craps_pkg::*;
#(
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             roll_valid,
   input  logic [SUM_W-1:0] sum,
   input  logic             new_game,
   output logic [1:0]       state,
   output logic [SUM_W-1:0] point,
   output logic             point_set,
   output logic             win,
   output logic             lose,
   output logic             game_over,
   output logic             sum_err,
   output logic [CNT_W-1:0] roll_count,
   output logic [CNT_W-1:0] win_count,
   output logic [CNT_W-1:0] loss_count
);

   craps_state_t st;
   logic         is_legal, is_win, is_lose;
   logic         in_play;

   assign in_play = (st == COME_OUT) || (st == POINT);

   craps_classify u_classify (
      .sum      (sum),
      .in_point (st == POINT),
      .point    (point),
      .is_legal (is_legal),
      .is_win   (is_win),
      .is_lose  (is_lose)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         st         <= COME_OUT;
         point      <= '0;
         game_over  <= 1'b0;
         sum_err    <= 1'b0;
         roll_count <= '0;
         win_count  <= '0;
         loss_count <= '0;
      end else begin
         game_over <= 1'b0;
         // illegal sums are flagged even when the roll itself is dropped
         sum_err   <= roll_valid && !is_legal;
         if (new_game) begin
            st         <= COME_OUT;
            point      <= '0;
            roll_count <= '0;
         end else if (roll_valid && is_legal && in_play) begin
            if (roll_count != '1)
               roll_count <= roll_count + CNT_W'(1);
            if (is_win) begin
               st        <= WIN;
               game_over <= 1'b1;
               if (win_count != '1)
                  win_count <= win_count + CNT_W'(1);
            end else if (is_lose) begin
               st        <= LOSE;
               game_over <= 1'b1;
               if (loss_count != '1)
                  loss_count <= loss_count + CNT_W'(1);
            end else if (st == COME_OUT) begin
               st    <= POINT;
               point <= sum;
            end
         end
      end
   end

   assign state     = st;
   assign point_set = (st == POINT);
   assign win       = (st == WIN);
   assign lose      = (st == LOSE);

endmodule

// File: tb/tb_craps_controller.sv
// Scoreboard bench: driver pushes the expected post-edge outputs from a
// rule-level game model; an independent monitor pops and compares each cycle.
module tb_craps_controller;

   localparam int CNT_W = 2;
   localparam int CMAX  = (1 << CNT_W) - 1;

   logic             clk = 1'b0;
   logic             rst, roll_valid, new_game;
   logic [3:0]       sum;
   logic [1:0]       state;
   logic [3:0]       point;
   logic             point_set, win, lose, game_over, sum_err;
   logic [CNT_W-1:0] roll_count, win_count, loss_count;

   always #5 clk = ~clk;

   craps_controller #(.CNT_W(CNT_W)) dut (
      .clk        (clk),
      .rst        (rst),
      .roll_valid (roll_valid),
      .sum        (sum),
      .new_game   (new_game),
      .state      (state),
      .point      (point),
      .point_set  (point_set),
      .win        (win),
      .lose       (lose),
      .game_over  (game_over),
      .sum_err    (sum_err),
      .roll_count (roll_count),
      .win_count  (win_count),
      .loss_count (loss_count)
   );

   typedef struct packed {
      logic [1:0]       state;
      logic [3:0]       point;
      logic             point_set, win, lose, game_over, sum_err;
      logic [CNT_W-1:0] rc, wc, lc;
   } obs_t;

   obs_t q[$];
   int   total = 0;
   int   bad   = 0;

   // game model: 0=come-out, 1=point, 2=won, 3=lost
   int m_phase = 0, m_point = 0, m_rolls = 0, m_wins = 0, m_losses = 0;

   function automatic int bump(input int v);
      return (v < CMAX) ? v + 1 : v;
   endfunction

   task automatic step(input bit r, input bit rv, input int s, input bit ng);
      obs_t e;
      bit   legal, ended, err;
      rst = r; roll_valid = rv; sum = 4'(s); new_game = ng;
      @(posedge clk);
      legal = (s >= 2) && (s <= 12);
      ended = 1'b0;
      err   = 1'b0;
      if (r) begin
         m_phase = 0; m_point = 0; m_rolls = 0; m_wins = 0; m_losses = 0;
      end else begin
         err = rv && !legal;
         if (ng) begin
            m_phase = 0; m_point = 0; m_rolls = 0;
         end else if (rv && legal && m_phase < 2) begin
            m_rolls = bump(m_rolls);
            if (m_phase == 0) begin
               if (s == 7 || s == 11)               m_phase = 2;
               else if (s == 2 || s == 3 || s == 12) m_phase = 3;
               else begin m_phase = 1; m_point = s; end
            end else begin
               if (s == m_point)  m_phase = 2;
               else if (s == 7)   m_phase = 3;
            end
            if (m_phase == 2) begin m_wins   = bump(m_wins);   ended = 1'b1; end
            if (m_phase == 3) begin m_losses = bump(m_losses); ended = 1'b1; end
         end
      end
      e.state     = 2'(m_phase);
      e.point     = 4'(m_point);
      e.point_set = (m_phase == 1);
      e.win       = (m_phase == 2);
      e.lose      = (m_phase == 3);
      e.game_over = ended;
      e.sum_err   = err;
      e.rc        = CNT_W'(m_rolls);
      e.wc        = CNT_W'(m_wins);
      e.lc        = CNT_W'(m_losses);
      q.push_back(e);
      @(negedge clk);
   endtask

   task automatic roll(input int s);
      step(1'b0, 1'b1, s, 1'b0);
   endtask

   task automatic ng();
      step(1'b0, 1'b0, 0, 1'b1);
   endtask

   // monitor: outputs are all registered, so each negedge shows one result
   always @(negedge clk) begin
      obs_t a, e;
      if (q.size() != 0) begin
         e = q.pop_front();
         a = {state, point, point_set, win, lose, game_over, sum_err,
              roll_count, win_count, loss_count};
         total++;
         if (a !== e) begin
            bad++;
            $display("FAIL cycle%0d outputs: got st=%0d pt=%0d ps=%b w=%b l=%b go=%b err=%b rc=%0d wc=%0d lc=%0d want st=%0d pt=%0d ps=%b w=%b l=%b go=%b err=%b rc=%0d wc=%0d lc=%0d",
                     total, a.state, a.point, a.point_set, a.win, a.lose, a.game_over,
                     a.sum_err, a.rc, a.wc, a.lc, e.state, e.point, e.point_set, e.win,
                     e.lose, e.game_over, e.sum_err, e.rc, e.wc, e.lc);
         end
      end
   end

   initial begin
      int sv;
      step(1'b1, 1'b0, 0, 1'b0);
      step(1'b1, 1'b1, 7, 1'b1);
      step(1'b0, 1'b0, 0, 1'b0);
      // natural win, then craps loss
      roll(7); step(1'b0, 1'b0, 0, 1'b0);
      ng(); roll(12);
      // point made
      ng(); roll(6); roll(5); roll(6);
      // seven-out, then rolls ignored while held in LOSE
      ng(); roll(8); roll(7); roll(7); roll(13);
      // illegal sum in come-out, then new_game overriding a legal roll
      ng(); roll(13); step(1'b0, 1'b1, 7, 1'b1);
      step(1'b0, 1'b1, 15, 1'b1);
      // win tally saturation at CNT_W=2
      for (int g = 0; g < 4; g++) begin ng(); roll(11); end
      // long point phase saturates roll_count, then reset mid-point
      ng(); roll(9); roll(4); roll(5); roll(6); roll(8);
      step(1'b1, 1'b1, 9, 1'b0);
      step(1'b0, 1'b0, 0, 1'b0);
      // abandon a game in point phase
      roll(10); ng();
      for (int i = 0; i < 600; i++) begin
         sv = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 15) : $urandom_range(2, 12);
         step($urandom_range(0, 63) == 0, $urandom_range(0, 2) != 0, sv,
              $urandom_range(0, 7) == 0);
      end
      rst = 1'b0; roll_valid = 1'b0; new_game = 1'b0; sum = '0;
      for (int w = 0; w < 4 && q.size() != 0; w++) @(negedge clk);
      total++;
      if (q.size() != 0) begin
         bad++;
         $display("FAIL drain: got %0d pending want 0", q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/craps_controller.md
Name: craps_controller

Overview:
- Game-control stage directly downstream of the two-dice Adder.
- Consumes the 4-bit dice sum (2..12) once per roll and runs the standard craps rules: come-out roll, point phase, win/lose.
- Keeps saturating tallies of rolls, wins and losses for the display stage that follows it.
- All outputs are registered.

Parameters:
- CNT_W, 8, width of the roll_count, win_count and loss_count tallies.

Ports:
- clk  in  1  single system clock; all logic on its rising edge.
- rst  in  1  synchronous, active-high reset.
- roll_valid  in  1  one-cycle strobe; sum is valid this cycle.
- sum  in  4  Adder output, unsigned; legal range 2..12.
- new_game  in  1  one-cycle strobe; leaves WIN/LOSE and starts a new game.
- state  out  2  current state encoding (see Behaviour).
- point  out  4  stored point value; 0 when no point is set.
- point_set  out  1  high while in POINT.
- win  out  1  high while in WIN.
- lose  out  1  high while in LOSE.
- game_over  out  1  one-cycle pulse on entry to WIN or LOSE.
- sum_err  out  1  one-cycle pulse when roll_valid arrives with an illegal sum.
- roll_count  out  CNT_W  accepted rolls in the current game; saturates at all-ones.
- win_count  out  CNT_W  games won since reset; saturates.
- loss_count  out  CNT_W  games lost since reset; saturates.

Behaviour:
- State encoding: COME_OUT=0, POINT=1, WIN=2, LOSE=3.
- Reset values: state=COME_OUT; point=0; all flags and pulses 0; all counters 0.
- Latency: a roll presented at edge N is reflected on every output after edge N+1 (one registered cycle).
- Illegal sum: roll_valid with sum in {0,1,13,14,15}.
  - sum_err pulses for one cycle.
  - State, point and roll_count are unchanged.
  - Checked in every state.
- Accepted roll: roll_valid with a legal sum in COME_OUT or POINT. roll_count increments, saturating.
- COME_OUT:
  - sum 7 or 11 -> WIN.
  - sum 2, 3 or 12 -> LOSE.
  - sum 4, 5, 6, 8, 9 or 10 -> POINT; point<=sum.
- POINT:
  - sum==point -> WIN.
  - sum==7 -> LOSE.
  - any other legal sum -> stay in POINT; only roll_count increments.
- Entering WIN: win_count increments (saturating); game_over pulses for one cycle.
- Entering LOSE: loss_count increments (saturating); game_over pulses for one cycle.
- WIN / LOSE:
  - Held indefinitely; roll_valid with a legal sum is ignored (no count, no error).
  - new_game -> COME_OUT; point<=0; roll_count<=0.
  - win_count and loss_count are kept.
- new_game in COME_OUT or POINT: abandons the game. Go to COME_OUT, point<=0, roll_count<=0; no tally change.
- new_game and roll_valid in the same cycle: new_game wins and the roll is dropped. sum_err may still pulse if that sum is illegal.
- Flag outputs decode directly from the registered state: win = (state==WIN), lose = (state==LOSE), point_set = (state==POINT).
- point holds its value through WIN/LOSE until new_game or reset.
- rst asserted mid-game: full return to reset values on that edge, overriding roll_valid and new_game.
- Counter saturation: at 2^CNT_W-1 the counter holds; no wrap.

Decomposition:
- craps_pkg holds:
  - the state enum;
  - constants SUM_W=4, SUM_MIN=2, SUM_MAX=12, SEVEN=7, ELEVEN=11;
  - the craps set {2,3,12}.
- Sub-module craps_classify (combinational):
  - Inputs: sum and phase (come-out or point) plus point.
  - Outputs: is_legal, is_win, is_lose.
  - Keeps the rule decode separate from the FSM/counter RTL so it can be unit-tested exhaustively over 16 sums x 2 phases.

Test Plan:
- Reset, then roll 7 -> next cycle state=2, win=1, game_over pulse, win_count=1, roll_count=1.
- new_game, roll 12 -> state=3, lose=1, loss_count=1, point=0.
- new_game, roll 6, 5, 6 -> after first roll point=6, point_set=1; after 5 state stays 1 with roll_count=2; after second 6 win=1, roll_count=3.
- new_game, roll 8, then 7 -> lose=1, loss_count=2; then roll 7 with no new_game -> nothing changes, no sum_err.
- In COME_OUT, roll sum=13 -> sum_err pulse, state=0, roll_count=0. Same cycle new_game=1 with a legal roll 7 -> roll dropped, state=0.
- CNT_W=2: win 4 games -> win_count stays 3. Assert rst while in POINT with point=9 -> all outputs return to reset values next cycle.
